// File: rtl/map_frame_sched.sv
// Frame sequencer for the MAP decoder: LOAD, FWD (alpha), BWD (beta/LLR).
// Drives buffer/metric addresses, stage enables and source/sink handshakes.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   start, abort    frame start (IDLE only); synchronous abort to IDLE
//   sym_valid/ready symbol source handshake; buf_we/buf_waddr buffer write
//   rd_addr         read address for FWD and BWD
//   alpha_en/init   alpha stage enable and initial-metric load
//   beta_en/init    beta stage enable and initial-metric load
//   llr_valid/ready LLR sink handshake
//   busy, done      frame in progress; end-of-frame pulse
module map_frame_sched #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              alpha_en,
  output logic              alpha_init,
  output logic              beta_en,
  output logic              beta_init,
  output logic              llr_valid,
  input  logic              llr_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FWD,
    S_BWD,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sym_ready  = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = '0;
    rd_addr    = '0;
    alpha_en   = 1'b0;
    alpha_init = 1'b0;
    beta_en    = 1'b0;
    beta_init  = 1'b0;
    llr_valid  = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
          cnt_nx   = '0;
        end
      end
      S_LOAD: begin
        sym_ready = 1'b1;
        buf_waddr = cnt;
        buf_we    = sym_valid;
        if (sym_valid) begin
          if (cnt == LAST) begin
            state_nx = S_FWD;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_FWD: begin
        alpha_en   = 1'b1;
        rd_addr    = cnt;
        alpha_init = (cnt == '0);
        if (cnt == LAST) begin
          state_nx = S_BWD;
          cnt_nx   = LAST;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_BWD: begin
        llr_valid = 1'b1;
        rd_addr   = cnt;
        beta_init = (cnt == LAST);
        beta_en   = llr_ready;
        if (llr_ready) begin
          if (cnt == '0) begin
            state_nx = S_DONE;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
    // Abort wins over any transition; the
    // same-cycle handshakes above still stand.
    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_map_frame_sched.sv
// Scoreboard bench for map_frame_sched.
// Stimulus pushes per-frame expectations; a monitor checks every handshake.
module tb_map_frame_sched;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       sym_valid;
  logic       sym_ready;
  logic       buf_we;
  logic [3:0] buf_waddr;
  logic [3:0] rd_addr;
  logic       alpha_en;
  logic       alpha_init;
  logic       beta_en;
  logic       beta_init;
  logic       llr_valid;
  logic       llr_ready;
  logic       busy;
  logic       done;

  map_frame_sched #(.FRAME_LEN(N), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .rd_addr(rd_addr),
    .alpha_en(alpha_en), .alpha_init(alpha_init),
    .beta_en(beta_en), .beta_init(beta_init),
    .llr_valid(llr_valid), .llr_ready(llr_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    bit init;
  } ev_t;

  int  wq[$];
  ev_t aq[$];
  ev_t bq[$];
  int  dq;
  int  total;
  int  bad;
  int  cyc;
  int  exp_done;
  int  done_seen;
  int  stall7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flush();
    wq.delete();
    aq.delete();
    bq.delete();
    dq = 0;
  endtask

  // Reference: a frame writes 0..N-1 once, reads alpha at
  // 0..N-1 (init at 0), then delivers LLRs at N-1..0
  // (init at N-1) and ends with one done.
  task automatic push_frame();
    ev_t e;
    for (int i = 0; i < N; i++) wq.push_back(i);
    for (int i = 0; i < N; i++) begin
      e.addr = i;
      e.init = (i == 0);
      aq.push_back(e);
    end
    for (int i = N - 1; i >= 0; i--) begin
      e.addr = i;
      e.init = (i == N - 1);
      bq.push_back(e);
    end
    dq++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (sym_ready) begin
        chk("wq_avail", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          chk("buf_waddr", int'(buf_waddr), wq[0]);
          chk("buf_we", int'(buf_we), int'(sym_valid));
          if (buf_we) void'(wq.pop_front());
        end
      end
      if (alpha_en) begin
        chk("aq_avail", int'(aq.size() > 0), 1);
        chk("fwd_no_llr", int'(llr_valid), 0);
        if (aq.size() > 0) begin
          chk("fwd_addr", int'(rd_addr), aq[0].addr);
          chk("alpha_init", int'(alpha_init),
              int'(aq[0].init));
          void'(aq.pop_front());
        end
      end
      if (llr_valid) begin
        chk("bq_avail", int'(bq.size() > 0), 1);
        if (bq.size() > 0) begin
          chk("bwd_addr", int'(rd_addr), bq[0].addr);
          chk("beta_init", int'(beta_init),
              int'(bq[0].init));
          chk("beta_en", int'(beta_en), int'(llr_ready));
          if (!llr_ready && rd_addr == 4'd7) stall7++;
          if (llr_ready) void'(bq.pop_front());
        end
      end
      if (done) begin
        chk("done_expected", int'(dq > 0), 1);
        chk("done_busy", int'(busy), 1);
        if (dq > 0) dq--;
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        done_seen++;
      end
    end
  end

  task automatic drive_idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      abort     = 1'b0;
      sym_valid = 1'(($urandom_range(0, 1)));
      llr_ready = 1'(($urandom_range(0, 1)));
    end
  endtask

  task automatic check_empty(string tag);
    chk({tag, "_wq"}, wq.size(), 0);
    chk({tag, "_aq"}, aq.size(), 0);
    chk({tag, "_bq"}, bq.size(), 0);
    chk({tag, "_dq"}, dq, 0);
  endtask

  // vm: 0 always valid, 1 every other cycle, 2 random
  // rm: 0 always ready, 1 random, 2 stall 3 cycles at 7
  // abort_k > 0: abort in cycle start+abort_k
  // exp_aq: expected alpha entries left after abort (-1 skip)
  task automatic run_frame(int vm, int rm, int abort_k,
                           int exp_aq, bit sib, bit timed);
    int  s;
    int  d0;
    int  sl;
    bit  stalled;
    bit  pulsed;
    bit  fin;
    push_frame();
    @(posedge clk);
    #1;
    start     = 1'b1;
    sym_valid = 1'b0;
    llr_ready = 1'b1;
    s         = cyc;
    exp_done  = timed ? s + 3 * N + 1 : -1;
    d0        = done_seen;
    sl        = 0;
    stalled   = 1'b0;
    pulsed    = 1'b0;
    fin       = 1'b0;
    stall7    = 0;
    for (int k = 1; k < 3000 && !fin; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (done_seen != d0) begin
        fin = 1'b1;
      end else if (abort_k > 0 && k == abort_k + 1) begin
        chk("abort_idle", int'(busy), 0);
        if (exp_aq >= 0) begin
          chk("abort_aq_left", aq.size(), exp_aq);
          chk("abort_wq_left", wq.size(), 0);
          chk("abort_bq_left", bq.size(), N);
        end
        flush();
        fin = 1'b1;
      end else begin
        if (sib && llr_valid && !pulsed) begin
          start  = 1'b1;
          pulsed = 1'b1;
        end
        case (vm)
          0:       sym_valid = 1'b1;
          1:       sym_valid = 1'((k % 2));
          default: sym_valid = ($urandom_range(0, 2) != 0);
        endcase
        case (rm)
          0: llr_ready = 1'b1;
          1: llr_ready = ($urandom_range(0, 2) != 0);
          default: begin
            if (sl > 0) begin
              llr_ready = 1'b0;
              sl--;
            end else if (!stalled && llr_valid &&
                         rd_addr == 4'd7) begin
              llr_ready = 1'b0;
              sl        = 2;
              stalled   = 1'b1;
            end else begin
              llr_ready = 1'b1;
            end
          end
        endcase
        abort = (abort_k > 0 && k == abort_k);
      end
    end
    if (!fin) begin
      chk("frame_timeout", 0, 1);
      flush();
    end
    exp_done = -1;
    drive_idle(6);
    check_empty("post");
  endtask

  task automatic check_zero(string name);
    chk(name, int'({sym_ready, buf_we, buf_waddr, rd_addr,
                    alpha_en, alpha_init, beta_en, beta_init,
                    llr_valid, busy, done}), 0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    dq        = 0;
    exp_done  = -1;
    done_seen = 0;
    stall7    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    sym_valid = 1'b1;
    llr_ready = 1'b1;
    #3;
    check_zero("reset_outs");
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_idle(4);
    chk("idle_no_busy", int'(busy), 0);

    // Plain frame: fixed latency to done.
    run_frame(0, 0, 0, -1, 1'b0, 1'b1);
    chk("done_count1", done_seen, 1);

    // Every-other-cycle source.
    run_frame(1, 0, 0, -1, 1'b0, 1'b0);

    // Sink stalls three cycles at address 7.
    run_frame(0, 2, 0, -1, 1'b0, 1'b0);
    chk("stall7_cycles", stall7, 3);

    // Abort in FWD with cnt == 5: 6 alpha reads done.
    run_frame(0, 0, N + 5 + 1, N - 6, 1'b0, 1'b0);
    chk("abort_no_done", done_seen, 3);
    run_frame(0, 0, 0, -1, 1'b0, 1'b1);

    // start during BWD is ignored.
    run_frame(0, 0, 0, -1, 1'b1, 1'b1);
    chk("sib_one_done", done_seen, 5);

    // Random handshakes, some with random aborts.
    for (int f = 0; f < 8; f++) begin
      if (f % 3 == 2)
        run_frame(2, 1, int'($urandom_range(1, 60)), -1,
                  1'b0, 1'b0);
      else
        run_frame(2, 1, 0, -1, 1'(f % 2), 1'b0);
    end

    // Asynchronous reset in LOAD with cnt == 9.
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b1;
    for (int k = 1; k <= N / 2 + 2; k++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      sym_valid = 1'b1;
    end
    chk("pre_rst_waddr", int'(buf_waddr), 9);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst_outs");
    flush();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive_idle(5);
    chk("post_rst_idle", int'(busy), 0);
    chk("post_rst_rdy", int'(sym_ready), 0);
    check_empty("rst");

    run_frame(0, 0, 0, -1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
